tmds_channel_decoder: RTL and testbench

Receive-side counterpart of our HDMI TMDS transmit path. Takes one TMDS channel's 10-bit parallel words from an external deserializer. Word-aligns them by issuing bitslip requests. Decodes each word into 8-bit video data, 2-bit control, TERC4 nibble or guard-band flags. Sits between the deserializer primitive and the HDMI receive top, with one instance per channel (blue/green/red).

---
 rtl/tmds_pkg.sv | 27 ++
 rtl/tmds_word_decode.sv | 52 +++++
 rtl/tmds_channel_decoder.sv | 151 +++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS code constants and alignment state type for the channel decoder
// and any future data-island parser.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;

  // Indexed by the TERC4 nibble value.
  localparam logic [9:0] TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } align_state_e;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational decode of one 10-bit TMDS word into video byte, control
// symbol, TERC4 nibble and guard-band flag.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       is_ctrl,
  output logic       is_terc4,
  output logic [3:0] terc4,
  output logic       is_guard
);

  logic [7:0] d;
  logic [7:0] vid;

  always_comb begin
    data     = '0;
    ctrl     = '0;
    is_ctrl  = 1'b0;
    is_terc4 = 1'b0;
    terc4    = '0;
    is_guard = 1'b0;

    d      = sym[9] ? ~sym[7:0] : sym[7:0];
    vid    = '0;
    vid[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      vid[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end

    case (sym)
      CTRL_TOK_00: begin is_ctrl = 1'b1; ctrl = 2'b00; end
      CTRL_TOK_01: begin is_ctrl = 1'b1; ctrl = 2'b01; end
      CTRL_TOK_10: begin is_ctrl = 1'b1; ctrl = 2'b10; end
      CTRL_TOK_11: begin is_ctrl = 1'b1; ctrl = 2'b11; end
      default: ;
    endcase

    for (int i = 0; i < 16; i++) begin
      if (sym == TERC4_CODE[i]) begin
        is_terc4 = 1'b1;
        terc4    = 4'(i);
      end
    end

    is_guard = (sym == GUARD_A) || (sym == GUARD_B);
    data     = is_ctrl ? 8'h00 : vid;
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment via bitslip requests plus a
// two-stage registered decode of the aligned words.
//
// state     | meaning
// SEARCH    | counting consecutive control tokens; slip on timeout
// SLIP_WAIT | bitslip issued, letting the deserializer settle
// LOCKED    | aligned; drop lock after a long stretch without tokens
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_HOLDOFF   = 4,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] sym_in,
  output logic       bitslip,
  output logic [3:0] slip_cnt,
  output logic       locked,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       is_ctrl,
  output logic       is_terc4,
  output logic [3:0] terc4,
  output logic       is_guard
);

  localparam int TMR_MAX0 = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int TMR_MAX  = (TMR_MAX0 > SLIP_HOLDOFF) ? TMR_MAX0 : SLIP_HOLDOFF;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam int RUN_W    = $clog2(CTRL_RUN + 1);

  logic [9:0]   sym_q;
  logic [7:0]   dec_data;
  logic [1:0]   dec_ctrl;
  logic         dec_is_ctrl;
  logic         dec_is_terc4;
  logic [3:0]   dec_terc4;
  logic         dec_is_guard;

  align_state_e state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic [3:0]   slip_nxt;
  logic         locked_nxt;
  logic         bitslip_nxt;

  tmds_word_decode u_dec (
    .sym      (sym_q),
    .data     (dec_data),
    .ctrl     (dec_ctrl),
    .is_ctrl  (dec_is_ctrl),
    .is_terc4 (dec_is_terc4),
    .terc4    (dec_terc4),
    .is_guard (dec_is_guard)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_q    <= '0;
      de       <= 1'b0;
      data     <= '0;
      ctrl     <= '0;
      is_ctrl  <= 1'b0;
      is_terc4 <= 1'b0;
      terc4    <= '0;
      is_guard <= 1'b0;
    end else begin
      sym_q    <= sym_in;
      de       <= ~dec_is_ctrl;
      data     <= dec_data;
      is_ctrl  <= dec_is_ctrl;
      is_terc4 <= dec_is_terc4;
      terc4    <= dec_terc4;
      is_guard <= dec_is_guard;
      if (dec_is_ctrl) ctrl <= dec_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      tmr      <= '0;
      run      <= '0;
      slip_cnt <= '0;
      locked   <= 1'b0;
      bitslip  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      run      <= run_nxt;
      slip_cnt <= slip_nxt;
      locked   <= locked_nxt;
      bitslip  <= bitslip_nxt;
    end
  end

  // One shared timer: search timeout, slip holdoff and loss-of-lock idle count.
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    run_nxt     = run;
    slip_nxt    = slip_cnt;
    locked_nxt  = locked;
    bitslip_nxt = 1'b0;

    case (state)
      SEARCH: begin
        run_nxt = dec_is_ctrl ? run + 1'b1 : '0;
        tmr_nxt = tmr + 1'b1;
        if (dec_is_ctrl && run == RUN_W'(CTRL_RUN - 1)) begin
          state_nxt  = LOCKED;
          locked_nxt = 1'b1;
          slip_nxt   = '0;
          tmr_nxt    = '0;
          run_nxt    = '0;
        end else if (tmr == TMR_W'(SEARCH_TIMEOUT - 1)) begin
          state_nxt   = SLIP_WAIT;
          bitslip_nxt = 1'b1;
          slip_nxt    = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
          tmr_nxt     = '0;
          run_nxt     = '0;
        end
      end
      SLIP_WAIT: begin
        run_nxt = '0;
        tmr_nxt = tmr + 1'b1;
        if (tmr == TMR_W'(SLIP_HOLDOFF - 1)) begin
          state_nxt = SEARCH;
          tmr_nxt   = '0;
        end
      end
      LOCKED: begin
        if (dec_is_ctrl) begin
          tmr_nxt = '0;
        end else if (tmr == TMR_W'(LOSS_TIMEOUT - 1)) begin
          state_nxt  = SEARCH;
          locked_nxt = 1'b0;
          tmr_nxt    = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: reference decode model, a
// bit-rotating deserializer model, and lock/loss timing checks.
module tb_tmds_channel_decoder;
  import tmds_pkg::*;

  localparam int ST = 4096;
  localparam int HO = 4;
  localparam int LT = 4096;
  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] TB_T4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] sym_in = '0;
  logic       bitslip, locked, de, is_ctrl, is_terc4, is_guard;
  logic [3:0] slip_cnt, terc4;
  logic [7:0] data;
  logic [1:0] ctrl;

  tmds_channel_decoder dut (
    .clk(clk), .reset_n(reset_n), .sym_in(sym_in), .bitslip(bitslip),
    .slip_cnt(slip_cnt), .locked(locked), .de(de), .data(data), .ctrl(ctrl),
    .is_ctrl(is_ctrl), .is_terc4(is_terc4), .terc4(terc4), .is_guard(is_guard)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      tag;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       is_ctrl;
    logic       is_terc4;
    logic [3:0] terc4;
    logic       is_guard;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0;
  bit         chk_en = 0, deser_on = 0;
  int         pulse_cnt = 0, pulse_base = 0, rel_cyc = 0;
  int         slip_times[$];
  logic       prev_slip = 1'b0;
  logic [9:0] prev_true = '0;
  logic [1:0] exp_ctrl = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [9:0] w);
    exp_t e;
    logic [7:0] d, q;
    d = w[9] ? ~w[7:0] : w[7:0];
    q = d ^ {d[6:0], 1'b0};
    if (!w[8]) q[7:1] = ~q[7:1];
    e.due = 0;
    e.tag = $sformatf("w%03h", w);
    e.is_ctrl = 1'b1;
    e.ctrl = 2'b00;
    case (w)
      TOK00: e.ctrl = 2'b00;
      TOK01: e.ctrl = 2'b01;
      TOK10: e.ctrl = 2'b10;
      TOK11: e.ctrl = 2'b11;
      default: e.is_ctrl = 1'b0;
    endcase
    e.de = ~e.is_ctrl;
    e.data = e.is_ctrl ? 8'h00 : q;
    e.is_terc4 = 1'b0;
    e.terc4 = 4'h0;
    for (int i = 0; i < 16; i++)
      if (w == TB_T4[i]) begin e.is_terc4 = 1'b1; e.terc4 = 4'(i); end
    e.is_guard = (w == 10'b1011001100) || (w == 10'b0100110011);
    return e;
  endfunction

  // One clock of stimulus: observe bitslip, retire due scoreboard entries, drive next word.
  task automatic tick_word(input logic [9:0] w);
    logic [19:0] cat;
    logic [9:0]  pw;
    exp_t        e;
    int          off;
    @(negedge clk);
    if (bitslip) begin
      chk("slip_in_lock", 32'(locked), 32'(0));
      chk("slip_consec", 32'(prev_slip), 32'(0));
      pulse_cnt++;
      slip_times.push_back(cyc);
    end
    prev_slip = bitslip;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk({e.tag, "_due"}, 32'(e.due), 32'(cyc));
      chk({e.tag, "_de"}, 32'(de), 32'(e.de));
      chk({e.tag, "_data"}, 32'(data), 32'(e.data));
      chk({e.tag, "_ctrl"}, 32'(ctrl), 32'(e.ctrl));
      chk({e.tag, "_is_ctrl"}, 32'(is_ctrl), 32'(e.is_ctrl));
      chk({e.tag, "_is_terc4"}, 32'(is_terc4), 32'(e.is_terc4));
      chk({e.tag, "_terc4"}, 32'(terc4), 32'(e.terc4));
      chk({e.tag, "_is_guard"}, 32'(is_guard), 32'(e.is_guard));
    end
    pw = w;
    if (deser_on) begin
      off = (3 + pulse_cnt - pulse_base) % 10;
      cat = {w, prev_true};
      pw  = cat[off +: 10];
    end
    prev_true = w;
    sym_in = pw;
    if (chk_en) begin
      e = model(pw);
      if (e.is_ctrl) exp_ctrl = e.ctrl;
      e.ctrl = exp_ctrl;
      e.due = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    slip_times.delete();
    exp_ctrl = '0;
    prev_slip = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;
    pulse_base = pulse_cnt;
  endtask

  initial begin
    int k;
    logic [3:0] last_sc;

    // Reset with random input, then the first search timeout.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sym_in = 10'($urandom);
      #1 chk("rst_outputs", 32'({bitslip, slip_cnt, locked, de, data, ctrl,
                                 is_ctrl, is_terc4, terc4, is_guard}), 32'(0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;
    pulse_base = pulse_cnt;
    repeat (ST - 1) tick_word(10'h1F0);
    #1 chk("no_slip_before_timeout", 32'(pulse_cnt - pulse_base), 32'(0));
    tick_word(10'h1F0);
    #1 chk("slip_at_timeout", 32'(pulse_cnt - pulse_base), 32'(1));
    chk("bitslip_high", 32'(bitslip), 32'(1));
    chk("slip_cnt_one", 32'(slip_cnt), 32'(1));
    reset_n = 1'b0;
    #1 chk("slip_async_drop", 32'(bitslip), 32'(0));
    chk("state_after_rst", 32'(dut.state), 32'(SEARCH));

    // Aligned blanking run locks after the 8th token.
    do_reset();
    chk_en = 1;
    repeat (8) tick_word(TOK00);
    tick_word(TOK00);
    #1 chk("lock_not_early", 32'(locked), 32'(0));
    tick_word(TOK00);
    #1 chk("locked_after_8", 32'(locked), 32'(1));
    chk("slip_cnt_at_lock", 32'(slip_cnt), 32'(0));
    chk("no_slip_aligned", 32'(pulse_cnt - pulse_base), 32'(0));

    // Video decode and held ctrl value.
    tick_word(10'h2FF);
    tick_word(10'h100);
    tick_word(TOK01);
    tick_word(10'h2FF);
    tick_word(TOK11);
    tick_word(TOK10);
    // TERC4 and guard-band classification.
    tick_word(10'b1010011100);
    tick_word(10'b1011001100);
    tick_word(10'b0100110011);
    for (int i = 0; i < 8; i++) tick_word(10'($urandom));
    repeat (4) tick_word(TOK00);

    // Loss of lock boundary.
    repeat (LT - 1) tick_word(10'h2FF);
    repeat (4) tick_word(TOK00);
    #1 chk("lock_hold_4095", 32'(locked), 32'(1));
    repeat (LT) tick_word(10'h2FF);
    tick_word(10'h2FF);
    #1 chk("lock_before_loss", 32'(locked), 32'(1));
    tick_word(10'h2FF);
    #1 chk("lock_lost", 32'(locked), 32'(0));
    chk("state_search_after_loss", 32'(dut.state), 32'(SEARCH));
    chk("no_slip_on_loss", 32'(bitslip), 32'(0));

    // Misaligned deserializer: 7 slips needed to bring a 3-bit offset round.
    chk_en = 0;
    do_reset();
    deser_on = 1;
    last_sc = '0;
    k = 0;
    while (!locked && k < 40000) begin
      tick_word(((k % 32) < 16) ? TOK00 : 10'($urandom_range(0, 1023)));
      if (!locked) last_sc = slip_cnt;
      k++;
    end
    chk("align_locked", 32'(locked), 32'(1));
    chk("align_pulses", 32'(pulse_cnt - pulse_base), 32'(7));
    chk("slip_cnt_prelock", 32'(last_sc), 32'(7));
    chk("slip_cnt_postlock", 32'(slip_cnt), 32'(0));
    if (slip_times.size() > 0)
      chk("first_slip_time", 32'(slip_times[0] - rel_cyc), 32'(ST));
    for (int i = 1; i < slip_times.size(); i++)
      chk("slip_spacing", 32'(slip_times[i] - slip_times[i-1]), 32'(ST + HO));
    repeat (2) tick_word(TOK00);
    chk_en = 1;
    for (int i = 0; i < 24; i++)
      tick_word((i % 3 == 0) ? TOK00 : 10'($urandom_range(0, 1023)));
    chk_en = 0;
    repeat (3) tick_word(TOK00);
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
